// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV64I core: walks each instruction through
// fetch/decode/execute/mem/writeback, drives datapath selects and counts retirements.
module cpu_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [6:0]  opcode_in,
  input  logic        imem_ready_in,
  input  logic        dmem_ready_in,
  input  logic        branch_taken_in,
  output logic        imem_req_out,
  output logic        ir_load_out,
  output logic [2:0]  imm_sel_out,
  output logic [1:0]  alu_a_sel_out,
  output logic        alu_b_sel_out,
  output logic        word_op_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic        reg_write_out,
  output logic [1:0]  wb_sel_out,
  output logic        pc_write_out,
  output logic [1:0]  pc_sel_out,
  output logic        trap_out,
  output logic [63:0] instret_out
);

  // The trap/boot path lives in the PC unit; only its alignment matters here.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_rv_chk
    $error("RESET_VECTOR must be 4-byte aligned");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_LOAD, C_STORE, C_OPIMM, C_OPIMM32, C_OP, C_OP32,
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_ILL
  } cls_e;

  state_e      state_q;
  cls_e        cls_q, dec_cls;
  logic [2:0]  imm_sel_q, dec_imm;
  logic [1:0]  alu_a_q, dec_a;
  logic        alu_b_q, dec_b;
  logic        word_q, dec_word;
  logic [1:0]  wb_sel_q, dec_wb;
  logic [1:0]  pc_sel_q, exec_pc_sel;
  logic [63:0] instret_q, instret_d;

  always_comb begin
    dec_cls  = C_ILL;
    dec_imm  = 3'd0;
    dec_a    = 2'd0;
    dec_b    = 1'b1;
    dec_word = 1'b0;
    dec_wb   = 2'd0;
    case (opcode_in)
      7'b0000011: begin dec_cls = C_LOAD;    dec_wb = 2'd1; end
      7'b0100011: begin dec_cls = C_STORE;   dec_imm = 3'd1; end
      7'b0010011: begin dec_cls = C_OPIMM;   end
      7'b0011011: begin dec_cls = C_OPIMM32; dec_word = 1'b1; end
      7'b0110011: begin dec_cls = C_OP;      dec_b = 1'b0; end
      7'b0111011: begin dec_cls = C_OP32;    dec_b = 1'b0; dec_word = 1'b1; end
      7'b0110111: begin dec_cls = C_LUI;     dec_imm = 3'd3; dec_a = 2'd2; end
      7'b0010111: begin dec_cls = C_AUIPC;   dec_imm = 3'd3; dec_a = 2'd1; end
      7'b1101111: begin dec_cls = C_JAL;     dec_imm = 3'd4; dec_a = 2'd1; dec_wb = 2'd2; end
      7'b1100111: begin dec_cls = C_JALR;    dec_wb = 2'd2; end
      7'b1100011: begin dec_cls = C_BRANCH;  dec_imm = 3'd2; dec_a = 2'd1; end
      default:    dec_cls = C_ILL;
    endcase
  end

  // Branch outcome is only valid in EXECUTE, so the PC select is resolved on that exit.
  always_comb begin
    exec_pc_sel = 2'd0;
    if (cls_q == C_JAL || (cls_q == C_BRANCH && branch_taken_in)) exec_pc_sel = 2'd1;
    else if (cls_q == C_JALR)                                      exec_pc_sel = 2'd2;
  end

  assign instret_d = instret_q + {63'd0, state_q == S_WB};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILL;
      imm_sel_q <= 3'd0;
      alu_a_q   <= 2'd0;
      alu_b_q   <= 1'b0;
      word_q    <= 1'b0;
      wb_sel_q  <= 2'd0;
      pc_sel_q  <= 2'd0;
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
      pc_sel_q  <= 2'd0;
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (imem_ready_in) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q     <= dec_cls;
          imm_sel_q <= dec_imm;
          alu_a_q   <= dec_a;
          alu_b_q   <= dec_b;
          word_q    <= dec_word;
          wb_sel_q  <= dec_wb;
          if (dec_cls == C_ILL) begin
            state_q  <= S_TRAP;
            pc_sel_q <= 2'd3;
          end else begin
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls_q == C_LOAD || cls_q == C_STORE) begin
            state_q <= S_MEM;
          end else begin
            state_q  <= S_WB;
            pc_sel_q <= exec_pc_sel;
          end
        end
        S_MEM:    if (dmem_ready_in) state_q <= S_WB;
        S_WB:     state_q <= S_FETCH;
        S_TRAP:   state_q <= S_FETCH;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req_out  = (state_q == S_FETCH);
  assign ir_load_out   = (state_q == S_FETCH) && imem_ready_in;
  assign dmem_req_out  = (state_q == S_MEM);
  assign dmem_we_out   = (state_q == S_MEM) && (cls_q == C_STORE);
  assign reg_write_out = (state_q == S_WB) && (cls_q != C_STORE) && (cls_q != C_BRANCH);
  assign pc_write_out  = (state_q == S_WB) || (state_q == S_TRAP);
  assign trap_out      = (state_q == S_TRAP);
  assign imm_sel_out   = imm_sel_q;
  assign alu_a_sel_out = alu_a_q;
  assign alu_b_sel_out = alu_b_q;
  assign word_op_out   = word_q;
  assign wb_sel_out    = wb_sel_q;
  assign pc_sel_out    = pc_sel_q;
  assign instret_out   = instret_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the RV64I core. Walks each instruction through fetch, decode, execute, memory and writeback, and drives all datapath selects, including the immediate-format select for the immediate generator. It handshakes with instruction and data memory, and it counts retired instructions. It sits between the instruction register/opcode field and the datapath muxes, register file and memory ports.

## Interface
- RESET_VECTOR, 64'h0, value presented on trap/boot PC path (exported only via pc_sel; kept for integration checks)
- clk_in  input  1  core clock; all state changes on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- opcode_in  input  7  instruction[6:0] from instruction register (valid from DECODE onward)
- imem_ready_in  input  1  instruction memory has data for current request
- dmem_ready_in  input  1  data memory completed current access
- branch_taken_in  input  1  ALU branch comparison result (valid in EXECUTE)
- imem_req_out  output  1  instruction fetch request
- ir_load_out  output  1  load instruction register
- imm_sel_out  output  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J
- alu_a_sel_out  output  2  0 rs1, 1 PC, 2 zero
- alu_b_sel_out  output  1  0 rs2, 1 immediate
- word_op_out  output  1  OP-32/OP-IMM-32 (32-bit op, sign-extend result)
- dmem_req_out  output  1  data memory request
- dmem_we_out  output  1  data write (store)
- reg_write_out  output  1  register file write enable
- wb_sel_out  output  2  0 ALU, 1 memory, 2 PC+4
- pc_write_out  output  1  PC update strobe
- pc_sel_out  output  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1, 3 trap vector
- trap_out  output  1  illegal-opcode pulse
- instret_out  output  64  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- IDLE is held during reset. It moves to FETCH on the first edge after rst_n_in deasserts.
- FETCH:
  - imem_req_out is high while in FETCH.
  - Stays in FETCH while imem_ready_in=0.
  - In the cycle imem_ready_in=1, ir_load_out=1 and next state is DECODE.
- DECODE (1 cycle): classify opcode_in.
  - Legal opcodes and imm_sel: LOAD 0000011 (I), STORE 0100011 (S), OP-IMM 0010011 (I), OP-IMM-32 0011011 (I), OP 0110011 (—, imm_sel=0), OP-32 0111011, LUI 0110111 (U), AUIPC 0010111 (U), JAL 1101111 (J), JALR 1100111 (I), BRANCH 1100011 (B).
  - Any other opcode goes to TRAP.
- Decoded selects are registered at DECODE exit and held until the next DECODE:
  - alu_a_sel: PC for AUIPC/JAL/BRANCH target; zero for LUI; rs1 otherwise.
  - alu_b_sel: 1 for all except OP/OP-32.
  - word_op: 1 for OP-32/OP-IMM-32.
- EXECUTE (1 cycle): LOAD/STORE go to MEM; all others go to WRITEBACK. branch_taken_in is captured here.
- MEM:
  - dmem_req_out=1, and dmem_we_out=1 for STORE.
  - Held until dmem_ready_in=1, then goes to WRITEBACK.
- WRITEBACK (1 cycle):
  - pc_write_out=1 in this cycle.
  - reg_write_out=1 except for STORE/BRANCH.
  - wb_sel: 1 for LOAD; 2 for JAL/JALR; 0 otherwise.
  - pc_sel: 1 for JAL or taken BRANCH; 2 for JALR; 0 otherwise.
  - instret increments.
  - Next state is FETCH.
- TRAP (1 cycle):
  - trap_out=1, pc_write_out=1, pc_sel_out=3.
  - No reg_write, no instret increment.
  - Next state is FETCH.
- instret_out is 64-bit and wraps from 2^64-1 to 0.
- Ready inputs outside the state that samples them are ignored.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All 1-bit outputs 0; all select outputs 0; instret_out=0.
- Strobe outputs are Moore, decoded from state (registered selects):
  - imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, trap.
  - Exception: ir_load_out = FETCH & imem_ready_in.
- Minimum latency, counted FETCH to the WRITEBACK edge inclusive:
  - ALU/branch/jump instructions take 4 cycles.
  - LOAD/STORE take 5 cycles.
  - Each ready-low cycle adds 1.
- Illegal instruction: FETCH, DECODE, TRAP = 3 cycles.
- Exactly one pc_write_out pulse per instruction or trap.
- Reset asserted mid-MEM or mid-FETCH drops requests the same cycle (asynchronous) without waiting for ready.

## Test plan
- Reset then release, imem_ready_in=1 constant, opcode 0010011:
  - IDLE then FETCH one cycle after release.
  - Sequence FETCH/DECODE/EXECUTE/WRITEBACK repeats every 4 cycles.
  - instret_out=1 after the first WRITEBACK.
- LOAD with dmem_ready_in low 3 cycles:
  - dmem_req_out high 4 cycles, dmem_we_out=0.
  - Then reg_write_out=1 and wb_sel_out=1 in WRITEBACK.
- STORE: imm_sel_out=1, dmem_we_out=1 during MEM; reg_write_out=0; pc_sel_out=0.
- BRANCH taken vs not taken:
  - Taken: imm_sel_out=2, pc_sel_out=1, no reg_write.
  - Not taken: pc_sel_out=0.
- JAL: imm_sel_out=4, wb_sel_out=2, pc_sel_out=1.
- JALR: imm_sel_out=0, pc_sel_out=2.
- Illegal opcode 1111111: trap_out one-cycle pulse with pc_sel_out=3, instret_out unchanged, then FETCH.
- Reset mid-MEM: dmem_req_out drops asynchronously, instret_out resets to 0.
- Counter wrap: preload instret to 2^64-1 by force, retire one instruction, expect 0.
